// File: rtl/fp_dot_product_ctrl.sv
// rtl/fp_dot_product_ctrl.sv - dot-product sequencer for a shared Q3.5 fixed-point multiplier
//
// Purpose:
//   Accepts vec_len operand pairs over a valid/ready stream. Each accepted
//   pair is registered onto the external multiplier inputs. The combinational
//   product is summed into an unsigned saturating accumulator one cycle later.
//   The finished sum is then offered on a valid/ready result port.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, vec_len        request a new dot product (sampled only in IDLE)
//   in_valid, in_ready    operand pair handshake
//   a_in, b_in            operand pair, Q3.5
//   mul_a, mul_b          registered operands to the external multiplier
//   mul_prod              multiplier product, (a*b)[12:5], same cycle
//   out_valid, out_ready  result handshake
//   result                accumulated sum, ACC_W bits with 5 fractional bits
//   busy                  controller is not idle
//   len_err               one-cycle pulse when start carries an illegal length

`timescale 1ns/1ps

module fp_dot_product_ctrl #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LEN);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_count;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_mul_a;
  logic [DATA_W-1:0]   r_mul_b;
  logic                r_op_vld;
  logic                r_len_err;

  logic                w_len_bad;
  logic                w_room;
  logic [LEN_W-1:0]    w_count_inc;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;
  logic                w_go;
  logic                w_err;
  logic                w_hs;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_acc_sat;

  assign w_len_bad   = (vec_len == '0) || (vec_len > LP_MAX_LEN);
  assign w_room      = (r_count < r_len);
  assign w_count_inc = r_count + LEN_W'(1);
  assign w_hs        = in_valid & w_in_ready;

  // The extra carry bit detects overflow. Because only non-negative values are
  // added, a saturated accumulator stays pinned at all-ones.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, mul_prod};
  assign w_acc_sat = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_go        = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          if (w_len_bad) begin
            w_err = 1'b1;
          end else begin
            w_go        = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_in_ready = w_room;
        // The pair that fills the vector moves the FSM to DRAIN.
        // That pair's product is still waiting to be accumulated.
        if (in_valid && w_room && (w_count_inc == r_len)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_op_vld  <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_err;
      // op_vld marks that mul_a/mul_b hold a fresh pair.
      // A bubble clears it, so no product is added that cycle.
      r_op_vld  <= w_hs;
      if (w_go) begin
        r_len   <= vec_len;
        r_count <= '0;
        r_acc   <= '0;
      end else begin
        if (w_hs) begin
          r_mul_a <= a_in;
          r_mul_b <= b_in;
          r_count <= w_count_inc;
        end
        if (r_op_vld) begin
          r_acc <= w_acc_sat;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign len_err   = r_len_err;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign result    = r_acc;

endmodule
